// File: rtl/nfi_sequencer.sv
// nfi_sequencer: sequences one next-field iteration over the double-buffered
// Game of Life field and arbitrates user edits against it.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   i_go              pulse: start an iteration (honoured only in IDLE)
//   i_row_done        pulse: row engine finished the current row
//   i_frame_end       pulse: end of visible display frame
//   i_edit_req        level: user edit pending, held until granted
//   o_NFI_allowed     pacing counter may launch a new iteration
//   o_row_start       pulse: row engine begins row o_row_idx
//   o_row_idx         current row index (holds between rows)
//   o_front_buf       buffer read by display/row engine; back = ~o_front_buf
//   o_edit_grant      pulse: edit may write the front buffer this cycle
//   o_busy            any state other than IDLE
//   o_gen_cnt         completed-iteration count (wraps)
module nfi_sequencer #(
    parameter  int FIELD_H = 32,
    parameter  int GEN_W   = 16,
    localparam int ROW_W   = $clog2(FIELD_H)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_go,
    input  logic             i_row_done,
    input  logic             i_frame_end,
    input  logic             i_edit_req,
    output logic             o_NFI_allowed,
    output logic             o_row_start,
    output logic [ROW_W-1:0] o_row_idx,
    output logic             o_front_buf,
    output logic             o_edit_grant,
    output logic             o_busy,
    output logic [GEN_W-1:0] o_gen_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        ROW_START,
        ROW_WAIT,
        SWAP_WAIT,
        EDIT
    } state_t;

    state_t             state, state_nxt;
    logic [ROW_W-1:0]   row;
    logic               front_buf;
    logic [GEN_W-1:0]   gen_cnt;
    logic               row_clr, row_inc, swap;
    logic               last_row;

    assign last_row = (row == ROW_W'(FIELD_H - 1));

    always_comb begin
        state_nxt = state;
        row_clr   = 1'b0;
        row_inc   = 1'b0;
        swap      = 1'b0;
        case (state)
            IDLE: begin
                // go wins over a simultaneous edit; the edit stays pending
                if (i_go) begin
                    state_nxt = ROW_START;
                    row_clr   = 1'b1;
                end else if (i_edit_req) begin
                    state_nxt = EDIT;
                end
            end
            ROW_START: state_nxt = ROW_WAIT;
            ROW_WAIT: begin
                if (i_row_done) begin
                    if (last_row) begin
                        state_nxt = SWAP_WAIT;
                    end else begin
                        state_nxt = ROW_START;
                        row_inc   = 1'b1;
                    end
                end
            end
            SWAP_WAIT: begin
                // swap only at frame end so the display never tears
                if (i_frame_end) begin
                    state_nxt = IDLE;
                    swap      = 1'b1;
                end
            end
            EDIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            row       <= '0;
            front_buf <= 1'b0;
            gen_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (row_clr)
                row <= '0;
            else if (row_inc)
                row <= row + ROW_W'(1);
            if (swap) begin
                front_buf <= ~front_buf;
                gen_cnt   <= gen_cnt + GEN_W'(1);
            end
        end
    end

    assign o_NFI_allowed = (state == IDLE) && !i_edit_req;
    assign o_row_start   = (state == ROW_START);
    assign o_row_idx     = row;
    assign o_front_buf   = front_buf;
    assign o_edit_grant  = (state == EDIT);
    assign o_busy        = (state != IDLE);
    assign o_gen_cnt     = gen_cnt;

endmodule

// File: tb/tb_nfi_sequencer.sv
// tb_nfi_sequencer: directed scenarios plus randomized traffic, checked every
// cycle against a progress-counter model of one iteration.
module tb_nfi_sequencer;
    localparam int H  = 4;
    localparam int GW = 2;

    logic          clk = 1'b0;
    logic          rst_n, i_go, i_row_done, i_frame_end, i_edit_req;
    logic          o_NFI_allowed, o_row_start, o_front_buf, o_edit_grant, o_busy;
    logic [1:0]    o_row_idx;
    logic [GW-1:0] o_gen_cnt;

    nfi_sequencer #(.FIELD_H(H), .GEN_W(GW)) dut (
        .clk(clk), .rst_n(rst_n), .i_go(i_go), .i_row_done(i_row_done),
        .i_frame_end(i_frame_end), .i_edit_req(i_edit_req),
        .o_NFI_allowed(o_NFI_allowed), .o_row_start(o_row_start),
        .o_row_idx(o_row_idx), .o_front_buf(o_front_buf),
        .o_edit_grant(o_edit_grant), .o_busy(o_busy), .o_gen_cnt(o_gen_cnt)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Model: pos is progress through the field. -1 idle, -2 granting an edit,
    // 2r = issuing row r, 2r+1 = waiting on row r, 2H = waiting for frame end.
    int pos, mrow, mfront, mgen;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            pos = -1; mrow = 0; mfront = 0; mgen = 0;
        end else if (pos == -1) begin
            if (i_go) begin pos = 0; mrow = 0; end
            else if (i_edit_req) pos = -2;
        end else if (pos == -2) begin
            pos = -1;
        end else if (pos == 2*H) begin
            if (i_frame_end) begin
                mfront = 1 - mfront;
                mgen   = (mgen + 1) % (1 << GW);
                pos    = -1;
            end
        end else if (pos % 2 == 0) begin
            pos++;
        end else if (i_row_done) begin
            pos++;
            mrow = (pos / 2 < H) ? pos / 2 : H - 1;
        end
    endtask

    task automatic compare();
        int e;
        logic [31:0] got;
        e = ((pos == -1 && !i_edit_req) ? 1 : 0) << 8;
        e |= ((pos >= 0 && pos < 2*H && pos % 2 == 0) ? 1 : 0) << 7;
        e |= mrow << 5;
        e |= mfront << 4;
        e |= ((pos == -2) ? 1 : 0) << 3;
        e |= ((pos != -1) ? 1 : 0) << 2;
        e |= mgen;
        got = {23'b0, o_NFI_allowed, o_row_start, o_row_idx, o_front_buf,
               o_edit_grant, o_busy, o_gen_cnt};
        chk("outputs{allow,start,idx,front,grant,busy,gen}", got, 32'(e));
    endtask

    // Entered just after a posedge; applies inputs for one full cycle.
    task automatic cyc(input logic go, input logic d, input logic fe,
                       input logic req, input logic rn);
        i_go = go; i_row_done = d; i_frame_end = fe; i_edit_req = req; rst_n = rn;
        @(negedge clk);
        compare();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Full iteration: go, then each row answered after gap wait cycles.
    task automatic run_iter(input int gap, input logic req);
        cyc(1, 0, 0, req, 1);
        for (int r = 0; r < H; r++) begin
            cyc(0, 0, 0, req, 1);
            for (int g = 0; g < gap; g++) cyc(0, 0, 0, req, 1);
            cyc(0, 1, 0, req, 1);
        end
        cyc(0, 0, 1, req, 1);
    endtask

    initial begin
        int eg[5];
        int ef[5];
        logic req_lvl;
        logic was_grant;
        eg = '{1, 2, 3, 0, 1};
        ef = '{1, 0, 1, 0, 1};

        i_go = 0; i_row_done = 0; i_frame_end = 0; i_edit_req = 0; rst_n = 0;
        pos = -1; mrow = 0; mfront = 0; mgen = 0;
        @(posedge clk);
        #1;
        cyc(0, 0, 0, 0, 0);
        chk("reset_busy",  32'(o_busy), 0);
        chk("reset_front", 32'(o_front_buf), 0);
        chk("reset_gen",   32'(o_gen_cnt), 0);
        chk("reset_row",   32'(o_row_idx), 0);
        chk("reset_pulses", 32'({o_row_start, o_edit_grant}), 0);

        // spurious row_done / frame_end in IDLE
        cyc(0, 1, 1, 0, 1);
        chk("idle_spurious_busy", 32'(o_busy), 0);

        // iteration with done 3 cycles after each start, go/frame_end noise
        cyc(1, 0, 0, 0, 1);
        for (int r = 0; r < H; r++) begin
            chk("t1_row_start", 32'({o_row_start, o_row_idx}), 32'({1'b1, 2'(r)}));
            cyc(0, 0, 0, 0, 1);
            cyc(1, 0, 1, 0, 1);
            cyc(0, 0, 0, 0, 1);
            cyc(0, 1, 0, 0, 1);
        end
        repeat (3) cyc(1, 1, 0, 0, 1);
        chk("t1_swap_hold", 32'({o_busy, o_front_buf, o_gen_cnt}), 32'({1'b1, 1'b0, 2'd0}));
        cyc(0, 0, 1, 0, 1);
        chk("t1_swapped", 32'({o_busy, o_front_buf, o_gen_cnt}), 32'({1'b0, 1'b1, 2'd1}));
        chk("t1_row_held", 32'(o_row_idx), 3);

        // edit request: allowed drops same cycle, grant next cycle, repeats
        i_edit_req = 1;
        #1;
        chk("t3_allowed_low", 32'(o_NFI_allowed), 0);
        cyc(0, 0, 0, 1, 1);
        chk("t3_grant1", 32'(o_edit_grant), 1);
        cyc(0, 0, 0, 1, 1);
        chk("t3_gap", 32'(o_edit_grant), 0);
        cyc(0, 0, 0, 1, 1);
        chk("t3_grant2", 32'(o_edit_grant), 1);
        cyc(0, 0, 0, 0, 1);
        chk("t3_idle", 32'({o_busy, o_edit_grant}), 0);

        // go + edit together: iteration first, grant after swap
        run_iter(0, 1);
        chk("t3b_after_swap", 32'({o_edit_grant, o_front_buf, o_gen_cnt}), 32'({1'b0, 1'b0, 2'd2}));
        cyc(0, 0, 0, 1, 1);
        chk("t3b_grant", 32'(o_edit_grant), 1);
        cyc(0, 0, 0, 0, 1);

        // reset while waiting on row 2
        cyc(1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1); cyc(0, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 1); cyc(0, 1, 0, 0, 1);
        cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 1);
        chk("t5_pre", 32'({o_busy, o_row_idx}), 32'({1'b1, 2'd2}));
        cyc(0, 0, 0, 0, 0);
        chk("t5_reset", 32'({o_busy, o_row_idx, o_front_buf, o_gen_cnt, o_row_start, o_edit_grant}), 0);

        // generation counter wrap
        for (int k = 0; k < 5; k++) begin
            run_iter(k % 2, 0);
            chk("t6_gen",   32'(o_gen_cnt), 32'(eg[k]));
            chk("t6_front", 32'(o_front_buf), 32'(ef[k]));
        end

        // randomized traffic
        req_lvl = 0;
        for (int n = 0; n < 4000; n++) begin
            if (!req_lvl && $urandom_range(7) == 0) req_lvl = 1;
            was_grant = (pos == -2);
            cyc($urandom_range(4) == 0, $urandom_range(2) == 0,
                $urandom_range(3) == 0, req_lvl, $urandom_range(149) != 0);
            if (was_grant) req_lvl = ($urandom_range(4) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/nfi_sequencer.md
Name: nfi_sequencer

Overview:
Sequences one next-field iteration (NFI) over the double-buffered Game of Life field. On each go pulse from the NFI pacing counter, it steps the row engine through every row. The engine reads the front buffer and writes the back buffer. When all rows are done, the buffers swap at the next display frame boundary. User cell edits share the field with the iteration, so the block also grants edit requests, but only while no iteration is in progress.

Parameters:
FIELD_H, 32, number of field rows (≥2)
GEN_W, 16, width of the generation counter
ROW_W, $clog2(FIELD_H), localparam: row index width

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
i_go  in  1  one-cycle pulse from the NFI pacing counter: start an iteration
i_row_done  in  1  one-cycle pulse from the row engine: current row written to back buffer
i_frame_end  in  1  one-cycle pulse from the display timing at end of visible frame
i_edit_req  in  1  level; user edit pending; held until granted
o_NFI_allowed  out  1  to the NFI pacing counter; high only when a new iteration may start
o_row_start  out  1  one-cycle pulse: row engine begins row o_row_idx
o_row_idx  out  ROW_W  current row index
o_front_buf  out  1  buffer read by display and row engine; back buffer = ~o_front_buf
o_edit_grant  out  1  one-cycle pulse: edit may write the front buffer this cycle
o_busy  out  1  high in any state other than IDLE
o_gen_cnt  out  GEN_W  completed-iteration count

Behaviour:
- All registers update on posedge clk. With rst_n=0 at a clock edge:
  - state=IDLE, row=0, o_front_buf=0, o_gen_cnt=0.
  - o_row_start=0, o_edit_grant=0, o_busy=0.
- Reset mid-iteration abandons the iteration with no swap and no count. The back buffer contents are then don't-care.
- States: IDLE, ROW_START, ROW_WAIT, SWAP_WAIT, EDIT.
- IDLE:
  - i_go=1 → ROW_START, row←0. i_go takes priority over a simultaneous i_edit_req; the request stays pending.
  - else i_edit_req=1 → EDIT.
- ROW_START:
  - o_row_start=1 for exactly this cycle, with o_row_idx=row.
  - Next state is ROW_WAIT unconditionally.
- ROW_WAIT:
  - i_row_done=1 with row==FIELD_H-1 → SWAP_WAIT.
  - i_row_done=1 otherwise → row←row+1, then ROW_START.
  - Minimum row period is therefore 2 cycles.
- SWAP_WAIT:
  - i_frame_end=1 → o_front_buf←~o_front_buf, o_gen_cnt←o_gen_cnt+1 (wraps modulo 2^GEN_W), then IDLE.
  - The new front buffer is visible from the next cycle. Swapping only at frame end prevents tearing.
- EDIT:
  - o_edit_grant=1 for exactly this cycle, then IDLE.
  - The requester must drop i_edit_req in the cycle after the grant. A still-high i_edit_req is treated as a new request.
- o_NFI_allowed = (state==IDLE) && !i_edit_req, combinational. A pending edit therefore freezes the pacing counter until the edit is served.
- Ignored inputs (no effect, no error):
  - i_go outside IDLE.
  - i_row_done outside ROW_WAIT.
  - i_frame_end outside SWAP_WAIT.
- o_row_idx holds its value between rows and after the iteration; it is reset to 0 only by reset or a new i_go.
- o_busy = (state != IDLE).

Test Plan:
1. Reset, FIELD_H=4: pulse i_go; answer each o_row_start with i_row_done 3 cycles later → rows 0,1,2,3 issued in order, o_busy=1. After the last done, SWAP_WAIT holds until i_frame_end. On i_frame_end, o_front_buf 0→1 and o_gen_cnt=1 next cycle, then IDLE.
2. i_go pulsed during ROW_WAIT and SWAP_WAIT → no restart; row sequence unaffected; o_gen_cnt increments exactly once.
3. i_edit_req=1 in IDLE → o_NFI_allowed=0 same cycle; o_edit_grant pulses once, 1 cycle later. Request held high → a grant every 2 cycles. Same-cycle i_go+i_edit_req → iteration runs first, grant after the swap.
4. Spurious i_row_done in IDLE/SWAP_WAIT and i_frame_end during ROW_WAIT → no state, row or buffer change.
5. rst_n=0 for one cycle while in ROW_WAIT at row 2 → next cycle IDLE, row 0, o_front_buf=0, o_gen_cnt=0, no grant/start pulses.
6. GEN_W=2: run 5 iterations → o_gen_cnt sequence 1,2,3,0,1; o_front_buf toggles each time (ends at 1).
